// File: rtl/multicycle_core.sv
// Multicycle CPU core: FSM-sequenced fetch/decode/execute/mem/writeback with
// a 4-entry register file, local data memory and a req/ack instruction port.
module multicycle_core #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DMEM_DEPTH = 32,
  parameter int unsigned PC_W       = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [11:0]       imem_rdata,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
  output logic              halted,
  output logic              retire,
  input  logic [1:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);

  localparam int unsigned INSTR_W = 12;
  localparam int unsigned AW      = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
  localparam int unsigned NREGS   = 4;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_ADDI = 3'd4;
  localparam logic [2:0] OP_LD   = 3'd5;
  localparam logic [2:0] OP_ST   = 3'd6;
  localparam logic [2:0] OP_BEQ  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [PC_W-1:0]     r_pc;
  logic [INSTR_W-1:0]  r_ir;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_res;
  logic [DATA_W-1:0]   r_mdr;
  logic [DATA_W-1:0]   r_rf  [NREGS];
  logic [DATA_W-1:0]   r_mem [DMEM_DEPTH];

  logic [2:0]          w_op;
  logic [1:0]          w_rd;
  logic [1:0]          w_rs1;
  logic [1:0]          w_rs2;
  logic [4:0]          w_imm;
  logic [DATA_W-1:0]   w_imm_ext;
  logic [DATA_W-1:0]   w_alu;
  logic [AW-1:0]       w_addr;
  logic                w_taken;
  logic [PC_W-1:0]     w_target;
  logic [PC_W-1:0]     w_pc_next;
  logic                w_pc_we;
  logic                w_retire;

  assign w_op      = r_ir[11:9];
  assign w_rd      = r_ir[8:7];
  assign w_rs1     = r_ir[6:5];
  assign w_rs2     = r_ir[4:3];
  assign w_imm     = r_ir[4:0];
  assign w_imm_ext = DATA_W'(w_imm);
  assign w_addr    = r_res[AW-1:0];
  assign w_taken   = (r_a == r_b);
  assign w_target  = w_imm[PC_W-1:0];
  assign w_pc_next = (w_op == OP_BEQ && w_taken) ? w_target : r_pc + PC_W'(1);

  // ALU; ADDI/LD/ST (and the unused BEQ result) all form rs1 + imm5
  always_comb begin
    w_alu = r_a + w_imm_ext;
    case (w_op)
      OP_ADD:  w_alu = r_a + r_b;
      OP_SUB:  w_alu = r_a - r_b;
      OP_AND:  w_alu = r_a & r_b;
      OP_OR:   w_alu = r_a | r_b;
      default: w_alu = r_a + w_imm_ext;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state; pc write and retire coincide on each instruction's final cycle
  always_comb begin
    w_next   = r_state;
    w_pc_we  = 1'b0;
    w_retire = 1'b0;
    case (r_state)
      S_IDLE:   if (start) w_next = S_FETCH;
      S_FETCH:  if (imem_ack) w_next = S_DECODE;
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        if (w_op == OP_LD || w_op == OP_ST) begin
          w_next = S_MEM;
        end else if (w_op == OP_BEQ) begin
          w_retire = 1'b1;
          w_pc_we  = 1'b1;
          w_next   = (w_taken && w_target == r_pc) ? S_HALT : S_FETCH;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        if (w_op == OP_LD) begin
          w_next = S_WB;
        end else begin
          w_retire = 1'b1;
          w_pc_we  = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_WB: begin
        w_retire = 1'b1;
        w_pc_we  = 1'b1;
        w_next   = S_FETCH;
      end
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc  <= '0;
      r_ir  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_mdr <= '0;
      for (int i = 0; i < int'(NREGS); i++) r_rf[i] <= '0;
    end else begin
      if (r_state == S_FETCH && imem_ack) r_ir <= imem_rdata;
      if (r_state == S_DECODE) begin
        r_a <= r_rf[w_rs1];
        r_b <= (w_op == OP_ST || w_op == OP_BEQ) ? r_rf[w_rd] : r_rf[w_rs2];
      end
      if (r_state == S_EXEC) r_res <= w_alu;
      if (r_state == S_MEM && w_op == OP_LD) r_mdr <= r_mem[w_addr];
      if (r_state == S_WB) r_rf[w_rd] <= (w_op == OP_LD) ? r_mdr : r_res;
      if (w_pc_we) r_pc <= w_pc_next;
    end
  end

  // Data memory keeps its contents across reset
  always_ff @(posedge clk) begin
    if (!reset && r_state == S_MEM && w_op == OP_ST) r_mem[w_addr] <= r_b;
  end

  assign imem_req  = (r_state == S_FETCH);
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign busy      = (r_state != S_IDLE) && (r_state != S_HALT);
  assign halted    = (r_state == S_HALT);
  assign retire    = w_retire;
  assign dbg_rdata = r_rf[dbg_raddr];

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: programs run from a bench-side imem with
// configurable ack wait; results read through the debug port.
module tb_multicycle_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        imem_req;
  logic [4:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [11:0] imem_rdata;
  logic [4:0]  pc;
  logic        busy;
  logic        halted;
  logic        retire;
  logic [1:0]  dbg_raddr = 2'd0;
  logic [7:0]  dbg_rdata;

  logic [11:0] prog [0:31];
  int          waitn = 0;
  int          wcnt  = 0;
  int          n_checks = 0;
  int          n_fail   = 0;

  multicycle_core #(.DATA_W(8), .DMEM_DEPTH(32), .PC_W(5)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .pc(pc), .busy(busy), .halted(halted),
    .retire(retire), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  assign imem_rdata = prog[imem_addr];

  // Instruction memory: acks after waitn stalled cycles of a held request
  always @(negedge clk) begin
    if (imem_req) begin
      if (wcnt >= waitn) imem_ack = 1'b1;
      else begin imem_ack = 1'b0; wcnt = wcnt + 1; end
    end else begin
      imem_ack = 1'b0;
      wcnt = 0;
    end
  end

  function automatic logic [11:0] rr(input logic [2:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs1, input logic [1:0] rs2);
    return {op, rd, rs1, rs2, 3'b000};
  endfunction

  function automatic logic [11:0] ri(input logic [2:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs1, input logic [4:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  // Every unused slot is a self-branch, so each program ends in HALT
  task automatic clear_prog();
    for (int i = 0; i < 32; i++) prog[i] = ri(3'd7, 2'd0, 2'd0, 5'(i));
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; start = 1'b0;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic go();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] r, output logic [7:0] v);
    dbg_raddr = r; #1; v = dbg_rdata;
  endtask

  task automatic run_cycles(input int n, output logic [63:0] m);
    m = '0;
    for (int c = 0; c < n; c++) begin
      if (retire === 1'b1) m[c] = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    do_reset();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b want 0", halted); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_checks++; if (retire !== 1'b0) begin n_fail++; $display("FAIL rst_retire: got %b want 0", retire); end
    n_checks++; if (pc !== 5'd0) begin n_fail++; $display("FAIL rst_pc: got %0d want 0", pc); end
    for (int r = 0; r < 4; r++) begin
      rd_reg(2'(r), v);
      n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL rst_R%0d: got %0h want 0", r, v); end
    end
  endtask

  task automatic test_add_seq(input int wt);
    logic [63:0] m;
    logic [63:0] exp_m;
    logic [7:0] v;
    logic bad;
    int n;
    clear_prog();
    prog[0] = ri(3'd4, 2'd1, 2'd0, 5'd5);
    prog[1] = ri(3'd4, 2'd2, 2'd0, 5'd3);
    prog[2] = rr(3'd0, 2'd3, 2'd1, 2'd2);
    waitn = wt;
    do_reset();
    go();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL add_busy: got %b want 1", busy); end
    n = 3 * (4 + wt);
    exp_m = '0;
    for (int i = 1; i <= 3; i++) exp_m[i * (4 + wt) - 1] = 1'b1;
    m = '0;
    bad = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (retire === 1'b1) m[c] = 1'b1;
      if (c <= wt && (imem_req !== 1'b1 || imem_addr !== 5'd0)) bad = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL add_req_hold wait=%0d: req not held at addr 0 for %0d cycles", wt, wt + 1); end
    n_checks++; if (m !== exp_m) begin n_fail++; $display("FAIL add_retire wait=%0d: got %0h want %0h", wt, m, exp_m); end
    n_checks++; if (pc !== 5'd3) begin n_fail++; $display("FAIL add_pc wait=%0d: got %0d want 3", wt, pc); end
    rd_reg(2'd3, v);
    n_checks++; if (v !== 8'd8) begin n_fail++; $display("FAIL add_R3 wait=%0d: got %0h want 8", wt, v); end
    rd_reg(2'd1, v);
    n_checks++; if (v !== 8'd5) begin n_fail++; $display("FAIL add_R1 wait=%0d: got %0h want 5", wt, v); end
    waitn = 0;
  endtask

  task automatic test_wrap();
    logic [63:0] m;
    logic [7:0] v;
    clear_prog();
    prog[0] = ri(3'd4, 2'd2, 2'd0, 5'd1);
    prog[1] = rr(3'd1, 2'd1, 2'd0, 2'd2);
    prog[2] = ri(3'd4, 2'd1, 2'd1, 5'd1);
    do_reset();
    go();
    run_cycles(8, m);
    rd_reg(2'd1, v);
    n_checks++; if (v !== 8'hFF) begin n_fail++; $display("FAIL sub_wrap: got %0h want ff", v); end
    run_cycles(4, m);
    rd_reg(2'd1, v);
    n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL addi_wrap: got %0h want 0", v); end
    n_checks++; if (pc !== 5'd3) begin n_fail++; $display("FAIL wrap_pc: got %0d want 3", pc); end
  endtask

  task automatic test_logic();
    logic [63:0] m;
    logic [7:0] v;
    clear_prog();
    prog[0] = ri(3'd4, 2'd1, 2'd0, 5'd12);
    prog[1] = ri(3'd4, 2'd2, 2'd0, 5'd10);
    prog[2] = rr(3'd2, 2'd3, 2'd1, 2'd2);
    prog[3] = rr(3'd3, 2'd0, 2'd1, 2'd2);
    do_reset();
    go();
    run_cycles(16, m);
    rd_reg(2'd3, v);
    n_checks++; if (v !== 8'd8) begin n_fail++; $display("FAIL and: got %0h want 8", v); end
    rd_reg(2'd0, v);
    n_checks++; if (v !== 8'd14) begin n_fail++; $display("FAIL or_R0: got %0h want e", v); end
    n_checks++; if (pc !== 5'd4) begin n_fail++; $display("FAIL logic_pc: got %0d want 4", pc); end
  endtask

  task automatic test_mem();
    logic [63:0] m;
    logic [7:0] v;
    clear_prog();
    prog[0] = ri(3'd4, 2'd1, 2'd0, 5'd20);
    prog[1] = rr(3'd0, 2'd1, 2'd1, 2'd1);
    prog[2] = rr(3'd0, 2'd1, 2'd1, 2'd1);
    prog[3] = rr(3'd0, 2'd1, 2'd1, 2'd1);
    prog[4] = ri(3'd4, 2'd1, 2'd1, 5'd5);
    prog[5] = ri(3'd6, 2'd1, 2'd0, 5'd31);
    prog[6] = ri(3'd5, 2'd2, 2'd0, 5'd31);
    prog[7] = ri(3'd5, 2'd3, 2'd1, 5'd26);
    do_reset();
    go();
    run_cycles(20, m);
    rd_reg(2'd1, v);
    n_checks++; if (v !== 8'hA5) begin n_fail++; $display("FAIL mem_R1: got %0h want a5", v); end
    run_cycles(9, m);
    n_checks++; if (m !== 64'h108) begin n_fail++; $display("FAIL st_ld_retire: got %0h want 108", m); end
    rd_reg(2'd2, v);
    n_checks++; if (v !== 8'hA5) begin n_fail++; $display("FAIL ld_R2: got %0h want a5", v); end
    n_checks++; if (pc !== 5'd7) begin n_fail++; $display("FAIL ld_pc: got %0d want 7", pc); end
    run_cycles(5, m);
    rd_reg(2'd3, v);
    n_checks++; if (v !== 8'hA5) begin n_fail++; $display("FAIL ld_addr_wrap: got %0h want a5", v); end
    n_checks++; if (pc !== 5'd8) begin n_fail++; $display("FAIL ld2_pc: got %0d want 8", pc); end
  endtask

  task automatic test_branch_halt();
    logic [63:0] m;
    logic [7:0] v;
    logic bad;
    clear_prog();
    prog[0] = ri(3'd7, 2'd0, 2'd0, 5'd3);
    prog[1] = ri(3'd4, 2'd3, 2'd0, 5'd7);
    prog[2] = ri(3'd4, 2'd3, 2'd0, 5'd7);
    prog[3] = ri(3'd4, 2'd1, 2'd0, 5'd1);
    prog[4] = ri(3'd7, 2'd1, 2'd0, 5'd0);
    prog[5] = ri(3'd7, 2'd0, 2'd0, 5'd5);
    do_reset();
    go();
    m = '0;
    bad = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (retire === 1'b1) m[c] = 1'b1;
      if (c >= 13 && imem_req !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (m !== 64'h1244) begin n_fail++; $display("FAIL beq_retire: got %0h want 1244", m); end
    n_checks++; if (bad) begin n_fail++; $display("FAIL halt_req: imem_req rose after HALT"); end
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halted: got %b want 1", halted); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL halt_busy: got %b want 0", busy); end
    n_checks++; if (pc !== 5'd5) begin n_fail++; $display("FAIL halt_pc: got %0d want 5", pc); end
    rd_reg(2'd3, v);
    n_checks++; if (v !== 8'd0) begin n_fail++; $display("FAIL beq_skip_R3: got %0h want 0", v); end
    rd_reg(2'd1, v);
    n_checks++; if (v !== 8'd1) begin n_fail++; $display("FAIL beq_R1: got %0h want 1", v); end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    n_checks++; if (halted !== 1'b1 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL halt_start: halted=%b req=%b want 1 0", halted, imem_req);
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [63:0] m;
    logic [7:0] v;
    logic bad;
    clear_prog();
    prog[0] = ri(3'd4, 2'd1, 2'd0, 5'd7);
    prog[1] = ri(3'd6, 2'd1, 2'd0, 5'd3);
    do_reset();
    go();
    run_cycles(7, m);
    n_checks++; if (retire !== 1'b1 || pc !== 5'd1) begin
      n_fail++; $display("FAIL st_mem_cycle: retire=%b pc=%0d want 1 1", retire, pc);
    end
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || imem_req !== 1'b0 || retire !== 1'b0 || halted !== 1'b0) begin
      n_fail++; $display("FAIL midrst_ctrl: busy=%b req=%b retire=%b halted=%b want 0 0 0 0", busy, imem_req, retire, halted);
    end
    n_checks++; if (pc !== 5'd0) begin n_fail++; $display("FAIL midrst_pc: got %0d want 0", pc); end
    rd_reg(2'd1, v);
    n_checks++; if (v !== 8'd0) begin n_fail++; $display("FAIL midrst_R1: got %0h want 0", v); end
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (imem_req !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL midrst_idle: activity after reset without start"); end
  endtask

  initial begin
    clear_prog();
    test_reset();
    test_add_seq(0);
    test_wrap();
    test_logic();
    test_mem();
    test_add_seq(3);
    test_branch_halt();
    test_reset_mid_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
